hazard_scoreboard: RTL

Parametrised hazard and forwarding scoreboard for the in-order pipeline. It tracks in-flight destination registers from EX to WB in a shift register of DEPTH slots and detects load-use hazards for any configured load latency. For NUM_RD source ports it produces the stall/issue handshake, registered per-port forwarding selects for EX, and an ID-stage writeback bypass. It replaces the fixed two-source, one-cycle load-use and forwarding logic.

---
 rtl/hazard_scoreboard.sv | 135 +++++++++++++
 1 files changed

// File: rtl/hazard_scoreboard.sv
// Hazard/forwarding scoreboard: tracks in-flight destinations EX..WB, stalls load-use, picks forwarding sources.
// Latency: id_ready and id_wb_bypass are combinational, ex_fwd_sel is registered on advance; hold freezes all state.
// Optional HAZARD_SB_PERF_CNT_EN adds saturating stall/bubble counters (ports tied to 0 otherwise).
module hazard_scoreboard #(
    parameter int  NUM_RD    = 2,
    parameter int  DEPTH     = 3,
    parameter int  LOAD_SLOT = 2,
    parameter int  AW        = 5,
    localparam int SELW      = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   id_valid,
    output logic                   id_ready,
    input  logic [NUM_RD*AW-1:0]   id_src_addr,
    input  logic [NUM_RD-1:0]      id_src_used,
    input  logic                   id_regwrite,
    input  logic [AW-1:0]          id_dest,
    input  logic                   id_is_load,
    input  logic                   hold,
    input  logic                   flush,
    input  logic                   ex_kill,
    output logic                   ex_valid,
    output logic [NUM_RD*SELW-1:0] ex_fwd_sel,
    output logic [NUM_RD-1:0]      id_wb_bypass,
    output logic                   wb_regwrite,
    output logic [AW-1:0]          wb_dest,
    output logic [31:0]            perf_stall_cnt,
    output logic [31:0]            perf_bubble_cnt
);

    logic [DEPTH-1:0] s_valid;
    logic [DEPTH-1:0] s_regwrite;
    logic [DEPTH-2:0] s_is_load;
    logic [AW-1:0]    s_dest [DEPTH];

    logic [DEPTH-1:0]  eff;
    logic              advance;
    logic              stall;
    logic              accept;
    logic [NUM_RD-1:0] port_act;
    logic [NUM_RD-1:0] port_hit;
    logic [NUM_RD-1:0] port_haz;
    logic [SELW-1:0]   port_sel [NUM_RD];

    assign advance = !hold;

    // ex_kill only takes effect on a cycle that actually advances
    always_comb begin
        for (int j = 0; j < DEPTH; j++) begin
            eff[j] = s_valid[j] && s_regwrite[j] && (s_dest[j] != '0);
        end
        if (ex_kill && advance) begin
            eff[0] = 1'b0;
        end
    end

    // Scan oldest to youngest so the youngest matching producer wins.
    always_comb begin
        for (int p = 0; p < NUM_RD; p++) begin
            port_act[p]     = id_src_used[p] && (id_src_addr[p*AW +: AW] != '0);
            port_hit[p]     = 1'b0;
            port_haz[p]     = 1'b0;
            port_sel[p]     = '0;
            for (int j = DEPTH-2; j >= 0; j--) begin
                if (eff[j] && (s_dest[j] == id_src_addr[p*AW +: AW])) begin
                    port_hit[p] = 1'b1;
                    port_sel[p] = SELW'(j + 1);
                    port_haz[p] = s_is_load[j] && ((j + 1) < LOAD_SLOT);
                end
            end
            id_wb_bypass[p] = id_valid && port_act[p] && !port_hit[p] && eff[DEPTH-1] &&
                              (s_dest[DEPTH-1] == id_src_addr[p*AW +: AW]);
        end
    end

    assign stall    = |(port_act & port_haz);
    assign id_ready = !reset && advance && !stall;
    assign accept   = id_valid && id_ready && !flush;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s_valid    <= '0;
            s_regwrite <= '0;
            s_is_load  <= '0;
            for (int j = 0; j < DEPTH; j++) begin
                s_dest[j] <= '0;
            end
            ex_fwd_sel <= '0;
        end else if (advance) begin
            for (int j = 1; j < DEPTH; j++) begin
                s_valid[j] <= s_valid[j-1];
                s_dest[j]  <= s_dest[j-1];
            end
            for (int j = 2; j < DEPTH; j++) begin
                s_regwrite[j] <= s_regwrite[j-1];
            end
            s_regwrite[1] <= s_regwrite[0] && !ex_kill;
            for (int j = 1; j < DEPTH-1; j++) begin
                s_is_load[j] <= s_is_load[j-1];
            end
            s_valid[0]    <= accept;
            s_regwrite[0] <= accept && id_regwrite;
            s_dest[0]     <= accept ? id_dest : '0;
            s_is_load[0]  <= accept && id_is_load;
            for (int p = 0; p < NUM_RD; p++) begin
                ex_fwd_sel[p*SELW +: SELW] <= (accept && port_act[p] && port_hit[p]) ? port_sel[p] : '0;
            end
        end
    end

    assign ex_valid    = s_valid[0];
    assign wb_regwrite = s_valid[DEPTH-1] && s_regwrite[DEPTH-1];
    assign wb_dest     = s_dest[DEPTH-1];

`ifdef HAZARD_SB_PERF_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_stall_cnt  <= '0;
            perf_bubble_cnt <= '0;
        end else begin
            if (id_valid && stall && advance && (perf_stall_cnt != 32'hFFFF_FFFF)) begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end
            if (advance && !accept && (perf_bubble_cnt != 32'hFFFF_FFFF)) begin
                perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
            end
        end
    end
`else
    assign perf_stall_cnt  = '0;
    assign perf_bubble_cnt = '0;
`endif

endmodule
